// File: rtl/shift_reg_pkg.sv
// Shared types for the universal shift register: operation select encoding.
package shift_reg_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        HOLD = 3'd0,
        LOAD = 3'd1,
        SHL  = 3'd2,
        SHR  = 3'd3,
        ROTL = 3'd4,
        ROTR = 3'd5,
        ASHR = 3'd6,
        CLR  = 3'd7
    } mode_t;

endpackage

// File: rtl/shift_reg_univ_dff_vec.sv
// Vector D flip-flop with synchronous active-high reset and clock enable.
// Latency: one cycle from d to q.
// Backpressure: none; en=0 holds q.
module dff_vec #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RST_VAL;
        end else if (en) begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/shift_reg_univ.sv
// Universal register: parallel load, logical/arithmetic/rotate shifts, clear.
// Latency: one cycle; out, ser_out and zero update together on the edge.
// Backpressure: none; en=0 freezes all state.
module shift_reg_univ
    import shift_reg_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] in,
    input  logic             ser_in,
    output logic [WIDTH-1:0] out,
    output logic             ser_out,
    output logic             zero
);

    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;
    logic             ser_out_d;
    logic             ser_out_q;
    logic             zero_d;
    logic             zero_q;

    always_comb begin
        out_d     = out_q;
        ser_out_d = ser_out_q;
        case (mode)
            HOLD: out_d = out_q;
            LOAD: out_d = in;
            SHL: begin
                out_d     = {out_q[WIDTH-2:0], ser_in};
                ser_out_d = out_q[WIDTH-1];
            end
            SHR: begin
                out_d     = {ser_in, out_q[WIDTH-1:1]};
                ser_out_d = out_q[0];
            end
            ROTL: begin
                out_d     = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
                ser_out_d = out_q[WIDTH-1];
            end
            ROTR: begin
                out_d     = {out_q[0], out_q[WIDTH-1:1]};
                ser_out_d = out_q[0];
            end
            ASHR: begin
                out_d     = {out_q[WIDTH-1], out_q[WIDTH-1:1]};
                ser_out_d = out_q[0];
            end
            CLR: begin
                out_d     = '0;
                ser_out_d = 1'b0;
            end
            default: out_d = out_q;
        endcase
        // Flag derived from the next word so it lands in the same cycle as out.
        zero_d = (out_d == '0);
    end

    dff_vec #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
    ) u_out_reg (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   (out_d),
        .q   (out_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ser_out_q <= 1'b0;
            zero_q    <= (RST_VAL == '0);
        end else if (en) begin
            ser_out_q <= ser_out_d;
            zero_q    <= zero_d;
        end
    end

    assign out     = out_q;
    assign ser_out = ser_out_q;
    assign zero    = zero_q;

endmodule
